// File: rtl/lp_tree_serializer_p.sv
// lp_tree_serializer_p: buffered parallel-to-serial converter; emitted bit picked by a binary mux tree.
// Define LP_SER_PARITY_EN to append an even-parity bit after the last data bit of every frame.
module lp_tree_serializer_p #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] PAR_IN,
    input  logic             PAR_VALID,
    output logic             PAR_READY,
    output logic             SERIAL_OUT,
    output logic             SERIAL_VALID,
    output logic             FRAME_START
);
    localparam int CW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("lp_tree_serializer_p: WIDTH must be a power of two in 2..64");
    end

    logic [WIDTH-1:0]   buf_word;
    logic [WIDTH-1:0]   cur_word;
    logic [WIDTH-1:0]   word_sel;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      idx_nxt;
    logic [CW-1:0]      sel;
    logic [2*WIDTH-2:0] node;
    logic               buf_full;
    logic               load;
    logic               last;
    logic               cnt_en;
    logic               nxt_valid;
    logic               nxt_out;
    logic               tree_bit;

    assign PAR_READY = !buf_full && RESET;
    assign load      = buf_full && (!SERIAL_VALID || last);
    assign word_sel  = load ? buf_word : cur_word;
    assign idx_nxt   = load ? '0 : cnt + CW'(1);
    assign sel       = MSB_FIRST ? ~idx_nxt : idx_nxt;
    assign nxt_valid = load || (SERIAL_VALID && !last);

`ifdef LP_SER_PARITY_EN
    logic par_phase;
    logic par_next;

    assign par_next = SERIAL_VALID && !par_phase && cnt == CW'(WIDTH - 1);
    assign last     = SERIAL_VALID && par_phase;
    assign cnt_en   = load || (SERIAL_VALID && !par_phase);
    assign nxt_out  = par_next ? ^cur_word : nxt_valid && tree_bit;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) par_phase <= 1'b0;
        else        par_phase <= par_next;
    end
`else
    assign last    = SERIAL_VALID && cnt == CW'(WIDTH - 1);
    assign cnt_en  = load || SERIAL_VALID;
    assign nxt_out = nxt_valid && tree_bit;
`endif

    // Level l holds WIDTH>>l nodes starting at 2*WIDTH - 2*(WIDTH>>l); the root is the top node.
    assign node[WIDTH-1:0] = word_sel;
    for (genvar l = 0; l < CW; l++) begin : g_lvl
        localparam int BI = 2 * WIDTH - 2 * (WIDTH >> l);
        localparam int BO = 2 * WIDTH - 2 * (WIDTH >> (l + 1));
        for (genvar i = 0; i < (WIDTH >> (l + 1)); i++) begin : g_mux
            assign node[BO+i] = sel[l] ? node[BI+2*i+1] : node[BI+2*i];
        end
    end
    assign tree_bit = node[2*WIDTH-2];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            buf_word     <= '0;
            buf_full     <= 1'b0;
            cur_word     <= '0;
            cnt          <= '0;
            SERIAL_OUT   <= 1'b0;
            SERIAL_VALID <= 1'b0;
            FRAME_START  <= 1'b0;
        end else begin
            if (PAR_VALID && PAR_READY) begin
                buf_word <= PAR_IN;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
            if (load) cur_word <= buf_word;
            if (cnt_en) cnt <= idx_nxt;
            SERIAL_OUT   <= nxt_out;
            SERIAL_VALID <= nxt_valid;
            FRAME_START  <= load;
        end
    end
endmodule

// File: tb/tb_lp_tree_serializer_p.sv
// tb_lp_tree_serializer_p: scoreboard bench for lp_tree_serializer_p at WIDTH 16 (both bit orders), 4 and 64.
// Frame lengths grow by one when LP_SER_PARITY_EN is defined.
module tb_lp_tree_serializer_p;
`ifdef LP_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL16 = 16 + P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] par_in = '0;
    logic        par_valid = 1'b0;
    logic        par_ready, s_out, s_valid, f_start;
    logic        l_ready, l_out, l_valid, l_fs;
    logic [3:0]  p4_in = '0;
    logic        p4_valid = 1'b0;
    logic        p4_ready, s4_out, s4_valid, s4_fs;
    logic [63:0] p64_in = '0;
    logic        p64_valid = 1'b0;
    logic        p64_ready, s64_out, s64_valid, s64_fs;

    logic [1:0]  q[$], ql[$], q4[$], q64[$];
    logic [1:0]  em, el, e4, e64;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    lp_tree_serializer_p #(.WIDTH(16), .MSB_FIRST(1)) dut (
        .CLK(clk), .RESET(rst_n), .PAR_IN(par_in), .PAR_VALID(par_valid), .PAR_READY(par_ready),
        .SERIAL_OUT(s_out), .SERIAL_VALID(s_valid), .FRAME_START(f_start));

    lp_tree_serializer_p #(.WIDTH(16), .MSB_FIRST(0)) dut_l (
        .CLK(clk), .RESET(rst_n), .PAR_IN(par_in), .PAR_VALID(par_valid), .PAR_READY(l_ready),
        .SERIAL_OUT(l_out), .SERIAL_VALID(l_valid), .FRAME_START(l_fs));

    lp_tree_serializer_p #(.WIDTH(4), .MSB_FIRST(0)) dut4 (
        .CLK(clk), .RESET(rst_n), .PAR_IN(p4_in), .PAR_VALID(p4_valid), .PAR_READY(p4_ready),
        .SERIAL_OUT(s4_out), .SERIAL_VALID(s4_valid), .FRAME_START(s4_fs));

    lp_tree_serializer_p #(.WIDTH(64), .MSB_FIRST(1)) dut64 (
        .CLK(clk), .RESET(rst_n), .PAR_IN(p64_in), .PAR_VALID(p64_valid), .PAR_READY(p64_ready),
        .SERIAL_OUT(s64_out), .SERIAL_VALID(s64_valid), .FRAME_START(s64_fs));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected stream per DUT: {frame_start, bit}, in emission order.
    task automatic push16(input logic [15:0] w);
        for (int k = 0; k < 16; k++) begin
            q.push_back({k == 0, w[15-k]});
            ql.push_back({k == 0, w[k]});
        end
`ifdef LP_SER_PARITY_EN
        q.push_back({1'b0, ^w});
        ql.push_back({1'b0, ^w});
`endif
    endtask

    task automatic push4(input logic [3:0] w);
        for (int k = 0; k < 4; k++) q4.push_back({k == 0, w[k]});
`ifdef LP_SER_PARITY_EN
        q4.push_back({1'b0, ^w});
`endif
    endtask

    task automatic push64(input logic [63:0] w);
        for (int k = 0; k < 64; k++) q64.push_back({k == 0, w[63-k]});
`ifdef LP_SER_PARITY_EN
        q64.push_back({1'b0, ^w});
`endif
    endtask

    // Offer a word, scrambling PAR_IN while the DUT is not ready; returns 1ns after the accepting edge.
    task automatic send(input logic [15:0] w);
        int t = 0;
        par_in = w;
        par_valid = 1'b1;
        while (!par_ready && t < 200) begin
            par_in = 16'($urandom);
            @(posedge clk);
            #1;
            t++;
        end
        chk("send_rdy", par_ready, 1);
        par_in = w;
        @(posedge clk);
        push16(w);
        #1;
        par_valid = 1'b0;
        par_in = 16'($urandom);
    endtask

    task automatic rand4(input int nw);
        logic [3:0] w;
        int t;
        for (int n = 0; n < nw; n++) begin
            w = 4'($urandom);
            t = 0;
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            p4_in = w;
            p4_valid = 1'b1;
            while (!p4_ready && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("r4_rdy", p4_ready, 1);
            @(posedge clk);
            push4(w);
            #1;
            p4_valid = 1'b0;
            p4_in = 4'($urandom);
        end
    endtask

    task automatic rand64(input int nw);
        logic [63:0] w;
        int t;
        for (int n = 0; n < nw; n++) begin
            w = {$urandom, $urandom};
            t = 0;
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
            p64_in = w;
            p64_valid = 1'b1;
            while (!p64_ready && t < 300) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("r64_rdy", p64_ready, 1);
            @(posedge clk);
            push64(w);
            #1;
            p64_valid = 1'b0;
            p64_in = {$urandom, $urandom};
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() + ql.size() + q4.size() + q64.size()) != 0 && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("drain_q", q.size(), 0);
        chk("drain_ql", ql.size(), 0);
    endtask

    task automatic stream2(input logic [15:0] a, input logic [15:0] b);
        send(a);
        fork
            begin
                send(b);
                chk("full_rdy", par_ready, 0);
                chk("full_rdy_l", l_ready, 0);
            end
            begin
                int nv = 0;
                @(negedge clk);
                for (int k = 0; k < 2 * FL16; k++) begin
                    @(negedge clk);
                    nv += int'(s_valid);
                end
                chk("contig", nv, 2 * FL16);
                @(negedge clk);
                chk("strm_end_v", s_valid, 0);
            end
        join
        drain();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid) begin
                if (q.size() == 0) chk("m_extra", 1, 0);
                else begin
                    em = q.pop_front();
                    chk("m_bit", s_out, em[0]);
                    chk("m_fs", f_start, em[1]);
                end
            end else chk("m_idle", {s_out, f_start}, 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (l_valid) begin
                if (ql.size() == 0) chk("l_extra", 1, 0);
                else begin
                    el = ql.pop_front();
                    chk("l_bit", l_out, el[0]);
                    chk("l_fs", l_fs, el[1]);
                end
            end else chk("l_idle", {l_out, l_fs}, 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n && s4_valid) begin
            if (q4.size() == 0) chk("w4_extra", 1, 0);
            else begin
                e4 = q4.pop_front();
                chk("w4_bit", s4_out, e4[0]);
                chk("w4_fs", s4_fs, e4[1]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s64_valid) begin
            if (q64.size() == 0) chk("w64_extra", 1, 0);
            else begin
                e64 = q64.pop_front();
                chk("w64_bit", s64_out, e64[0]);
                chk("w64_fs", s64_fs, e64[1]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", par_ready, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_out", s_out, 0);
        chk("rst_fs", f_start, 0);
        rst_n = 1'b1;
        #1 chk("rel_rdy", par_ready, 1);

        // Single word: idle latency, then underrun after the frame.
        send(16'hC5AF);
        @(negedge clk);
        chk("lat0_v", s_valid, 0);
        @(negedge clk);
        chk("lat1_v", s_valid, 1);
        chk("lat1_fs", f_start, 1);
        drain();
        @(negedge clk);
        chk("undr_v", s_valid, 0);
        chk("undr_out", s_out, 0);

        // Single word for the LSB-first instance pattern.
        send(16'h8811);
        drain();

        stream2(16'hFF00, 16'hF00F);
        stream2(16'hA995, 16'h0001);

        // Reset at bit 7 of the first word with a second word buffered.
        send(16'hCC33);
        send(16'hA815);
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid_v", s_valid, 0);
        chk("rmid_out", s_out, 0);
        chk("rmid_fs", f_start, 0);
        chk("rmid_rdy", par_ready, 0);
        q.delete();
        ql.delete();
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            nv += int'(s_valid) + int'(l_valid);
        end
        chk("rst_remnant", nv, 0);
        send(16'h1234);
        drain();

        fork
            rand4(40);
            rand64(12);
        join
        drain();
        chk("drain_q4", q4.size(), 0);
        chk("drain_q64", q64.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lp_tree_serializer_p.md
LP_TREE_SERIALIZER_P -- requirements
Module: lp_tree_serializer_p

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, parallel word width; power of two, 2..64.
REQ-002 SHALL provide parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PAR_IN  input  WIDTH  parallel word to serialise.
REQ-006 SHALL have port PAR_VALID  input  1  PAR_IN holds a valid word.
REQ-007 SHALL have port PAR_READY  output  1  block can accept a word this cycle.
REQ-008 SHALL have port SERIAL_OUT  output  1  serial data bit, registered.
REQ-009 SHALL have port SERIAL_VALID  output  1  SERIAL_OUT carries a frame bit, registered.
REQ-010 SHALL have port FRAME_START  output  1  high with the first bit of each frame, registered.

Function
REQ-011 SHALL accept a word on a rising edge where PAR_VALID and PAR_READY are both 1; no other edge accepts.
REQ-012 SHALL hold one accepted word in a next-word buffer; PAR_READY = buffer empty AND RESET high, derived from registered state only.
REQ-013 SHALL move the buffered word into a current-word register only at a word boundary, i.e. when idle or on the edge emitting the last frame bit; the buffer frees in that same edge.
REQ-014 SHALL write the current-word register only on that transfer, never per bit; no shift register.
REQ-015 SHALL select the emitted bit with a log2(WIDTH)-level binary mux tree indexed by a log2(WIDTH)-bit bit counter.
REQ-016 Idle latency: word accepted at edge T SHALL present its first bit on SERIAL_OUT after edge T+1, with SERIAL_VALID=1 and FRAME_START=1.
REQ-017 SHALL emit one bit per cycle in MSB_FIRST order for WIDTH consecutive cycles; FRAME_START=1 only on the first.
REQ-018 Streaming: if the next word is buffered by the edge emitting the current last frame bit, its first bit SHALL follow on the very next edge, with no idle cycle.
REQ-019 Underrun: with no buffered word at the last frame bit, the next edge SHALL set SERIAL_VALID=0, SERIAL_OUT=0, FRAME_START=0 until a word is transferred.
REQ-020 PAR_IN changes while PAR_READY=0 SHALL have no effect on the stream.
REQ-021 Bit counter SHALL wrap from the last index to 0 at each frame boundary.
REQ-022 A non-power-of-two WIDTH, or WIDTH outside 2..64, SHALL cause an elaboration error.

Reset
REQ-023 While RESET=0: SERIAL_OUT=0, SERIAL_VALID=0, FRAME_START=0, PAR_READY=0; buffer empty; counter 0.
REQ-024 Reset asserted mid-frame SHALL immediately discard the in-flight and buffered words.
REQ-025 The first edge after RESET rises SHALL see PAR_READY=1.

Configuration
REQ-026 Macro LP_SER_PARITY_EN SHALL, when defined, append one even-parity bit (XOR of the word) after the last data bit: SERIAL_VALID=1, FRAME_START=0, frame length WIDTH+1.
REQ-027 Without LP_SER_PARITY_EN the frame length SHALL be WIDTH and no parity logic SHALL exist.
REQ-028 With parity, word transfer and streaming rules SHALL treat the parity bit as the last frame bit.

Verification (WIDTH=16, MSB_FIRST=1 unless stated)
REQ-029 Reset then single word 16'hC5AF accepted at edge T -> SERIAL_OUT 1100010110101111 on edges T+1..T+16, FRAME_START only at T+1, SERIAL_VALID=0 from T+17.
REQ-030 Back-to-back 16'hFF00 then 16'hF00F with PAR_VALID held -> 32 contiguous valid bits, FRAME_START at bits 0 and 16, PAR_READY low while buffer full.
REQ-031 MSB_FIRST=0, word 16'h8811 -> bit stream 1000100000010001 (bit 0 first).
REQ-032 RESET low at bit 7 of 16'hCC33 with 16'hA815 buffered -> outputs 0 immediately; after release no remnant of either word appears.
REQ-033 LP_SER_PARITY_EN defined, words 16'hA995 then 16'h0001 streamed -> 17-bit frames, parity bits 0 then 1, second FRAME_START 17 edges after the first.
REQ-034 WIDTH=4 and WIDTH=64 builds, random words with random PAR_VALID gaps -> deserialised stream matches input order, no dropped or duplicated word.
